// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - SimpleRisc instruction-fetch stage with IF/OF pipeline register
//
// Purpose:
//   Owns the program counter, presents it to instruction_memory, and latches
//   the returned word with its PC into the IF/OF register. Handles branch
//   redirect/flush, downstream stall, and stops fetching on hlt.
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-high reset
//   stall          in   1   hold PC and IF/OF (overridden by branch_taken)
//   branch_taken   in   1   redirect to branch_target and flush IF/OF
//   branch_target  in  32   redirect address (low two bits ignored)
//   instr_addr     out 32   fetch address to instruction_memory (= pc)
//   instruction    in  32   word returned combinationally for instr_addr
//   if_of_pc       out 32   PC of the latched instruction
//   if_of_instr    out 32   latched instruction word
//   if_of_valid    out  1   latched instruction is real (0 = bubble)
//   halted         out  1   fetch stopped on hlt

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter logic [31:0] NOP_INSN = 32'b01101000000000000000000000000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_addr,
  input  logic [31:0] instruction,
  output logic [31:0] if_of_pc,
  output logic [31:0] if_of_instr,
  output logic        if_of_valid,
  output logic        halted
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [31:0] PC_INC   = 32'(PC_STEP);
  localparam logic [4:0]  HLT_OP   = 5'b11111;

  logic [31:0] pc;
  logic [0:0]  state;
  logic [31:0] redirect_pc;
  logic [31:0] next_seq_pc;
  logic        is_hlt;

  assign instr_addr = pc;

  // Instructions are word-aligned; a misaligned target is rounded down so
  // that addresses 1..3 mod 4 never reach memory.
  assign redirect_pc = branch_target & 32'hFFFF_FFFC;

  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 becomes 0.
  assign next_seq_pc = pc + PC_INC;

  assign is_hlt = (instruction[31:27] == HLT_OP);

  // halted is exactly the HALTED state; no separate flop to keep in sync.
  assign halted = (state == ST_HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= ST_RUN;
      if_of_pc    <= 32'h0000_0000;
      if_of_instr <= NOP_INSN;
      if_of_valid <= 1'b0;
    end else if (branch_taken) begin
      // Flush wins over stall, and a redirect also cancels a halt that was
      // fetched down the wrong path.
      pc          <= redirect_pc;
      state       <= ST_RUN;
      if_of_pc    <= pc;
      if_of_instr <= NOP_INSN;
      if_of_valid <= 1'b0;
    end else if (stall) begin
      pc          <= pc;
      state       <= state;
      if_of_pc    <= if_of_pc;
      if_of_instr <= if_of_instr;
      if_of_valid <= if_of_valid;
    end else if (state == ST_RUN) begin
      // Zero-latency memory: the word for pc is captured on the same edge
      // that advances pc.
      if_of_pc    <= pc;
      if_of_instr <= instruction;
      if_of_valid <= 1'b1;
      if (is_hlt) begin
        // hlt itself goes downstream as a valid instruction; pc stays on it.
        pc    <= pc;
        state <= ST_HALTED;
      end else begin
        pc    <= next_seq_pc;
        state <= ST_RUN;
      end
    end else begin
      // Halted: keep feeding bubbles until a redirect arrives.
      pc          <= pc;
      state       <= ST_HALTED;
      if_of_pc    <= pc;
      if_of_instr <= NOP_INSN;
      if_of_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h6800_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instr_addr;
  logic [31:0] instruction;
  logic [31:0] if_of_pc;
  logic [31:0] if_of_instr;
  logic        if_of_valid;
  logic        halted;

  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;
  bit running = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] if_pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [31:0] m_pc, m_if_pc, m_if_instr;
  logic        m_valid, m_halted;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_addr    (instr_addr),
    .instruction   (instruction),
    .if_of_pc      (if_of_pc),
    .if_of_instr   (if_of_instr),
    .if_of_valid   (if_of_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  assign instruction = mem[instr_addr[9:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_if_pc = 32'h0; m_if_instr = NOP; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // One clock edge of fetch behaviour, straight from the stage's rules.
  task automatic model_step(input bit s, input bit br, input logic [31:0] tgt);
    logic [31:0] w;
    if (br) begin
      m_if_pc = m_pc; m_if_instr = NOP; m_valid = 1'b0;
      m_pc = {tgt[31:2], 2'b00};
      m_halted = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (!m_halted) begin
      w = mem[m_pc[9:2]];
      m_if_pc = m_pc; m_if_instr = w; m_valid = 1'b1;
      if (w[31:27] == 5'b11111) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end else begin
      m_if_pc = m_pc; m_if_instr = NOP; m_valid = 1'b0;
    end
  endtask

  // Called at a falling edge: drive inputs, predict, wait one full cycle.
  task automatic cycle(input bit s, input bit br, input logic [31:0] tgt);
    exp_t e;
    stall = s; branch_taken = br; branch_target = tgt;
    model_step(s, br, tgt);
    e.pc = m_pc; e.if_pc = m_if_pc; e.instr = m_if_instr; e.valid = m_valid; e.halted = m_halted;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare every post-edge DUT output against the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && running) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("instr_addr", instr_addr, e.pc);
        chk("addr_align", {30'd0, instr_addr[1:0]}, 32'd0);
        chk("if_of_pc", if_of_pc, e.if_pc);
        chk("if_of_instr", if_of_instr, e.instr);
        chk("if_of_valid", {31'd0, if_of_valid}, {31'd0, e.valid});
        chk("halted", {31'd0, halted}, {31'd0, e.halted});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h4800_0000 | 32'(i);
    mem[25] = 32'hF800_0000;  // hlt at byte address 100

    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", instr_addr, 32'h0);
    chk("rst_if_pc", if_of_pc, 32'h0);
    chk("rst_instr", if_of_instr, NOP);
    chk("rst_valid", {31'd0, if_of_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    reset = 1'b0;
    running = 1'b1;

    // Three normal fetches: 0, 4, 8 -> pc 12
    repeat (3) cycle(0, 0, 0);
    // Stall two edges at pc 12, then resume
    repeat (2) cycle(1, 0, 0);
    cycle(0, 0, 0);
    // Walk to pc 68
    repeat (13) cycle(0, 0, 0);
    chk("pc_at_68", m_pc, 32'd68);
    // Branch with simultaneous stall -> flush wins
    cycle(1, 1, 32'h30);
    cycle(0, 0, 0);
    // Redirect to hlt at 100, fetch it, then bubbles (and a stall while halted)
    cycle(0, 1, 32'd100);
    cycle(0, 0, 0);
    repeat (2) cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    // Redirect out of HALTED with misaligned target
    cycle(0, 1, 32'h61);
    repeat (2) cycle(0, 0, 0);
    // Wrap from the top of the address space
    cycle(0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // Asynchronous reset mid-cycle at pc 0x30
    cycle(0, 1, 32'h30);
    chk("pre_rst_addr", instr_addr, 32'h30);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_addr", instr_addr, 32'h0);
    chk("async_rst_valid", {31'd0, if_of_valid}, 32'd0);
    chk("async_rst_instr", if_of_instr, NOP);
    chk("async_rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Randomized phase with fresh memory contents
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 15) == 0) w[31:27] = 5'b11111;
      else if (w[31:27] == 5'b11111) w[31] = 1'b0;
      mem[i] = w;
    end
    for (int n = 0; n < 1500; n++) begin
      bit s, br;
      logic [31:0] tgt;
      s  = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      else tgt = 32'($urandom_range(0, 1023));
      cycle(s, br, tgt);
    end

    running = 1'b0;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch (IF) stage of the SimpleRisc pipeline.
- Owns the program counter and drives the address input of instruction_memory.
- Latches the returned instruction and its PC into the IF/OF pipeline register for the operand-fetch stage.
- Handles branch redirect/flush, pipeline stall, and halt detection (hlt, opcode 5'b11111).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per fetched instruction (memory is byte-addressed, one instruction per 4 addresses).
- NOP_INSN, 32'b01101000000000000000000000000000, bubble word inserted on flush/halt.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall from the downstream interlock; hold PC and IF/OF.
- branch_taken  input  1  branch resolved taken this cycle; redirect and flush.
- branch_target  input  32  redirect address.
- instr_addr  output  32  address to instruction_memory (combinational = pc).
- instruction  input  32  instruction word returned combinationally for instr_addr.
- if_of_pc  output  32  PC of the latched instruction.
- if_of_instr  output  32  latched instruction word.
- if_of_valid  output  1  latched instruction is real (0 = bubble).
- halted  output  1  fetch has stopped on hlt.

Behaviour:
- One clock domain. Reset is asynchronous and active-high; the ports are named clk and reset.
- Reset values:
  - pc = RESET_PC, so instr_addr = RESET_PC.
  - if_of_pc = 0, if_of_instr = NOP_INSN, if_of_valid = 0, halted = 0.
  - state = RUN.
- instr_addr = pc, combinational. Instruction-memory latency is zero, so the instruction is captured on the same edge that advances pc.
- States:
  - RUN: fetching.
  - HALTED: hlt fetched and no redirect seen since.
- Edge priority, both states: branch_taken > stall > normal.
- branch_taken = 1:
  - pc <= {branch_target[31:2], 2'b00}; the low 2 bits are forced to zero.
  - if_of_instr <= NOP_INSN, if_of_valid <= 0, if_of_pc <= pc.
  - state <= RUN, halted <= 0.
  - Applies even when stall = 1, because a flush overrides the stall.
  - A redirect in HALTED cancels the halt; that hlt was on the wrong path.
- stall = 1, branch_taken = 0: pc, all IF/OF outputs, state and halted are held unchanged.
- RUN, normal edge:
  - if_of_instr <= instruction, if_of_pc <= pc, if_of_valid <= 1.
  - If instruction[31:27] == 5'b11111: pc is held, state <= HALTED, halted <= 1. The hlt itself is passed downstream with valid = 1.
  - Otherwise: pc <= pc + PC_STEP, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- HALTED, normal edge: pc held; if_of_instr <= NOP_INSN, if_of_valid <= 0, if_of_pc <= pc.
- Reset asserted mid-operation immediately forces all reset values, regardless of stall or branch_taken.
- Fetch addresses 1–3 modulo 4 are never produced; memory entries between instructions are never fetched.

Test Plan:
- Reset, then 3 normal cycles with memory holding mov words at addresses 0, 4, 8 -> instr_addr sequence 0, 4, 8, 12; if_of_pc = 0, 4, 8; if_of_valid = 1 from the first edge.
- Async reset asserted mid-cycle at pc = 32'h30 -> instr_addr = 0, if_of_valid = 0, if_of_instr = 32'h6800_0000 before the next clock edge.
- stall = 1 for 2 cycles at pc = 12 -> pc and IF/OF unchanged for both edges; fetch resumes at 12, with if_of_pc = 12 on the following edge.
- branch_taken = 1, branch_target = 32'h30 at pc = 68, with stall = 1 at the same edge -> pc = 48, if_of_valid = 0, if_of_instr = NOP_INSN; next edge latches instruction @48.
- hlt word 32'hF800_0000 at address 100 -> if_of_instr = hlt with valid = 1, halted = 1, instr_addr stuck at 100; later edges give valid = 0 bubbles.
- In HALTED, branch_taken = 1 with target 32'h61 -> pc = 32'h60, halted = 0, normal fetch resumes.
- pc preset to 32'hFFFF_FFFC via branch, then one normal edge -> pc = 0.
